// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU for the execute stage (16-op WISC set).
//
// Stage 1 registers the operands and opcode. Stage 2 computes the operation and registers
// Result and flags. Both ends use a valid/ready handshake with full backpressure. With no
// stall the latency from accept to out_valid is 2 cycles and throughput is 1 op/cycle.
//
// Parameters:
//   WIDTH  operand/result width (power of two, >= 8)
//   SHW    shift-amount bits, equal to log2(WIDTH)
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  input handshake; transfer when both are high
//   A, B, OP_Code       operands and operation select
//   out_valid, out_ready output handshake; transfer when both are high
//   Result              operation result
//   CF, ZF, SF, OF      carry, zero, sign and signed-overflow flags
//   bad_op              result came from the reserved opcode 15
module alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP_Code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             CF,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             bad_op
);

    localparam int unsigned HALF = WIDTH / 2;

    typedef enum logic [3:0] {
        OpAdd     = 4'd0,
        OpSub     = 4'd1,
        OpXor     = 4'd2,
        OpAndn    = 4'd3,
        OpRotl    = 4'd4,
        OpShl     = 4'd5,
        OpRotr    = 4'd6,
        OpShr     = 4'd7,
        OpEq      = 4'd8,
        OpLt      = 4'd9,
        OpLe      = 4'd10,
        OpCarry   = 4'd11,
        OpRev     = 4'd12,
        OpPassB   = 4'd13,
        OpLoadBot = 4'd14,
        OpBad     = 4'd15
    } op_e;

    // ------------------------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------------------------
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    op_e              s1_op_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cf_q;
    logic             zf_q;
    logic             sf_q;
    logic             of_q;
    logic             bad_q;

    logic             s2_load;

    // S2 takes a new value (possibly a bubble) whenever it is empty or being drained;
    // S1 hands over under the same condition, so S1 frees up in that cycle too.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    // ------------------------------------------------------------------------------------
    // Stage 1: operand register
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OpAdd;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_a_q  <= A;
                s1_b_q  <= B;
                s1_op_q <= op_e'(OP_Code);
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Stage 2: execute
    // ------------------------------------------------------------------------------------
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_of;
    logic             sub_of;
    logic             lt_s;
    logic             eq;
    logic [WIDTH-1:0] rot_l;
    logic [WIDTH-1:0] rot_r;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] res_d;
    logic             cf_d;
    logic             of_d;

    // Only the low SHW bits of B select the shift amount.
    assign sh = s1_b_q[SHW-1:0];

    assign add_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    // B - A as B + ~A + 1 so the carry-out reads as "no borrow".
    assign sub_sum = {1'b0, s1_b_q} + {1'b0, ~s1_a_q} + {{WIDTH{1'b0}}, 1'b1};

    assign add_of = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    assign sub_of = (s1_b_q[WIDTH-1] != s1_a_q[WIDTH-1]) &&
                    (sub_sum[WIDTH-1] != s1_b_q[WIDTH-1]);

    // Direct signed compare; no reliance on a subtraction sign, so overflow cannot corrupt it.
    assign lt_s = $signed(s1_a_q) < $signed(s1_b_q);
    assign eq   = s1_a_q == s1_b_q;

    // Rotates through a doubled operand; sh == 0 naturally returns A.
    assign rot_l = WIDTH'(({s1_a_q, s1_a_q} << sh) >> WIDTH);
    assign rot_r = WIDTH'({s1_a_q, s1_a_q} >> sh);
    assign shl   = s1_a_q << sh;
    assign shr   = s1_a_q >> sh;

    always_comb begin
        rev = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rev[i] = s1_a_q[int'(WIDTH) - 1 - i];
        end
    end

    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        of_d  = 1'b0;
        unique case (s1_op_q)
            OpAdd: begin
                res_d = add_sum[WIDTH-1:0];
                cf_d  = add_sum[WIDTH];
                of_d  = add_of;
            end
            OpSub: begin
                res_d = sub_sum[WIDTH-1:0];
                cf_d  = sub_sum[WIDTH];
                of_d  = sub_of;
            end
            OpXor:     res_d = s1_a_q ^ s1_b_q;
            OpAndn:    res_d = s1_a_q & ~s1_b_q;
            OpRotl:    res_d = rot_l;
            OpShl:     res_d = shl;
            OpRotr:    res_d = rot_r;
            OpShr:     res_d = shr;
            OpEq:      res_d = {{(WIDTH-1){1'b0}}, eq};
            OpLt:      res_d = {{(WIDTH-1){1'b0}}, lt_s};
            OpLe:      res_d = {{(WIDTH-1){1'b0}}, lt_s || eq};
            OpCarry:   res_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
            OpRev:     res_d = rev;
            OpPassB:   res_d = s1_b_q;
            OpLoadBot: res_d = {s1_a_q[HALF-1:0], s1_b_q[HALF-1:0]};
            OpBad:     res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            cf_q       <= 1'b0;
            zf_q       <= 1'b0;
            sf_q       <= 1'b0;
            of_q       <= 1'b0;
            bad_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            // Data only changes with a real op, so idle outputs hold their last value.
            if (s1_valid_q) begin
                result_q <= res_d;
                cf_q     <= cf_d;
                zf_q     <= res_d == '0;
                sf_q     <= res_d[WIDTH-1];
                of_q     <= of_d;
                bad_q    <= s1_op_q == OpBad;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign Result    = result_q;
    assign CF        = cf_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;
    assign OF        = of_q;
    assign bad_op    = bad_q;

endmodule
